// File: rtl/slot_pkg.sv
// ----------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the slot sequencer and the slot register bank:
//   - slot status encodings (EMPTY / READY / DONE / ERROR)
//   - sequencer state enum
//   - default width constants shared with the slot bank
// No ports (package).
// ----------------------------------------------------------------------------
package slot_pkg;

    localparam int unsigned DEF_NUM_SLOTS       = 2;
    localparam int unsigned DEF_INPUT_IDX_WIDTH = 1;
    localparam int unsigned DEF_SRC_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_SRC_SIZE_WIDTH  = 26;
    localparam int unsigned DEF_STATUS_WIDTH    = 2;
    localparam int unsigned DEF_PROFILE_WIDTH   = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 4096;

    localparam logic [1:0] STATUS_EMPTY = 2'd0;
    localparam logic [1:0] STATUS_READY = 2'd1;
    localparam logic [1:0] STATUS_DONE  = 2'd2;
    localparam logic [1:0] STATUS_ERROR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RCFG,
        ST_DMA_CMD,
        ST_DMA_WAIT,
        ST_WRBACK,
        ST_NEXT,
        ST_FINISH
    } seq_state_e;

endpackage

// File: rtl/slot_sequencer_if.sv
// ----------------------------------------------------------------------------
// slot_sequencer_if
// Bundles every non-clock/reset signal of the slot sequencer:
//   control   : start, busy, pass_done
//   slot read : rd_idx, rd_src_addr, rd_src_size, rd_status, rd_profile
//   slot write: wr_idx, wr_status, wr_set_status
//   DFX       : rcfg_req, rcfg_profile, rcfg_ack
//   DMA       : dma_cmd_valid/ready/addr/size, dma_done, dma_err
// Modports: master = the sequencer, slave = its environment.
// ----------------------------------------------------------------------------
interface slot_sequencer_if #(
    parameter int unsigned INPUT_IDX_WIDTH = slot_pkg::DEF_INPUT_IDX_WIDTH,
    parameter int unsigned SRC_ADDR_WIDTH  = slot_pkg::DEF_SRC_ADDR_WIDTH,
    parameter int unsigned SRC_SIZE_WIDTH  = slot_pkg::DEF_SRC_SIZE_WIDTH,
    parameter int unsigned STATUS_WIDTH    = slot_pkg::DEF_STATUS_WIDTH,
    parameter int unsigned PROFILE_WIDTH   = slot_pkg::DEF_PROFILE_WIDTH
) ();

    logic                       start;
    logic                       busy;
    logic                       pass_done;
    logic [INPUT_IDX_WIDTH-1:0] rd_idx;
    logic [SRC_ADDR_WIDTH-1:0]  rd_src_addr;
    logic [SRC_SIZE_WIDTH-1:0]  rd_src_size;
    logic [STATUS_WIDTH-1:0]    rd_status;
    logic [PROFILE_WIDTH-1:0]   rd_profile;
    logic [INPUT_IDX_WIDTH-1:0] wr_idx;
    logic [STATUS_WIDTH-1:0]    wr_status;
    logic                       wr_set_status;
    logic                       rcfg_req;
    logic [PROFILE_WIDTH-1:0]   rcfg_profile;
    logic                       rcfg_ack;
    logic                       dma_cmd_valid;
    logic                       dma_cmd_ready;
    logic [SRC_ADDR_WIDTH-1:0]  dma_cmd_addr;
    logic [SRC_SIZE_WIDTH-1:0]  dma_cmd_size;
    logic                       dma_done;
    logic                       dma_err;

    modport master (
        input  start, rd_src_addr, rd_src_size, rd_status, rd_profile,
               rcfg_ack, dma_cmd_ready, dma_done, dma_err,
        output busy, pass_done, rd_idx, wr_idx, wr_status, wr_set_status,
               rcfg_req, rcfg_profile, dma_cmd_valid, dma_cmd_addr, dma_cmd_size
    );

    modport slave (
        output start, rd_src_addr, rd_src_size, rd_status, rd_profile,
               rcfg_ack, dma_cmd_ready, dma_done, dma_err,
        input  busy, pass_done, rd_idx, wr_idx, wr_status, wr_set_status,
               rcfg_req, rcfg_profile, dma_cmd_valid, dma_cmd_addr, dma_cmd_size
    );

endinterface

// File: rtl/slot_seq_watchdog.sv
// ----------------------------------------------------------------------------
// slot_seq_watchdog
// Cycle counter bounding how long the sequencer may wait in a handshake state.
// Only instantiated when SLOT_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   active_i    : sequencer is in a waiting state (RCFG / DMA_CMD / DMA_WAIT)
//   clear_i     : a state change happens at the next edge; restart from 0
//   expired_o   : current cycle is the TIMEOUT_CYCLES-th cycle in the state
// ----------------------------------------------------------------------------
module slot_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = slot_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count 0 in the first cycle of a state, so expiry lands on cycle TIMEOUT_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/slot_sequencer.sv
// ----------------------------------------------------------------------------
// slot_sequencer
// Scans slots 0..NUM_SLOTS-1 once per start pulse. Each READY slot is
// reconfigured if its profile differs from the loaded one, gets one DMA
// command, and has DONE or ERROR written back to its status.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slot_sequencer_if.master (control, slot bank read/write,
//                DFX request/ack, DMA command/completion)
// Optional feature: define SLOT_SEQ_TIMEOUT_EN to bound every wait by
// TIMEOUT_CYCLES; an expired wait writes ERROR (RCFG timeout also forgets
// the loaded profile).
// ----------------------------------------------------------------------------
module slot_sequencer
    import slot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int unsigned INPUT_IDX_WIDTH = DEF_INPUT_IDX_WIDTH,
    parameter int unsigned SRC_ADDR_WIDTH  = DEF_SRC_ADDR_WIDTH,
    parameter int unsigned SRC_SIZE_WIDTH  = DEF_SRC_SIZE_WIDTH,
    parameter int unsigned STATUS_WIDTH    = DEF_STATUS_WIDTH,
    parameter int unsigned PROFILE_WIDTH   = DEF_PROFILE_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input logic              clk,
    input logic              reset,
    slot_sequencer_if.master bus
);

    if (NUM_SLOTS < 1 || NUM_SLOTS > (2 ** INPUT_IDX_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("slot_sequencer: illegal parameter combination");
    end

    seq_state_e                 state_q, state_d;
    logic [INPUT_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [SRC_ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [SRC_SIZE_WIDTH-1:0]  cur_size_q, cur_size_d;
    logic [PROFILE_WIDTH-1:0]   cur_prof_q, cur_prof_d;
    logic [PROFILE_WIDTH-1:0]   loaded_prof_q, loaded_prof_d;
    logic                       loaded_valid_q, loaded_valid_d;
    logic [STATUS_WIDTH-1:0]    result_q, result_d;
    logic                       timeout_hit;

`ifdef SLOT_SEQ_TIMEOUT_EN
    logic wait_state;

    assign wait_state = (state_q == ST_RCFG) || (state_q == ST_DMA_CMD) ||
                        (state_q == ST_DMA_WAIT);

    slot_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .active_i (wait_state),
        .clear_i  (state_d != state_q),
        .expired_o(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers; reset also forgets the loaded profile.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cur_addr_q     <= '0;
            cur_size_q     <= '0;
            cur_prof_q     <= '0;
            loaded_prof_q  <= '0;
            loaded_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cur_addr_q     <= cur_addr_d;
            cur_size_q     <= cur_size_d;
            cur_prof_q     <= cur_prof_d;
            loaded_prof_q  <= loaded_prof_d;
            loaded_valid_q <= loaded_valid_d;
            result_q       <= result_d;
        end
    end

    // Next-state logic. A completed handshake in the same cycle as a timeout
    // wins, so a transfer the environment already accepted is never lost.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cur_addr_d     = cur_addr_q;
        cur_size_d     = cur_size_q;
        cur_prof_d     = cur_prof_q;
        loaded_prof_d  = loaded_prof_q;
        loaded_valid_d = loaded_valid_q;
        result_d       = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                cur_addr_d = bus.rd_src_addr;
                cur_size_d = bus.rd_src_size;
                cur_prof_d = bus.rd_profile;
                if (bus.rd_status != STATUS_WIDTH'(STATUS_READY)) begin
                    state_d = ST_NEXT;
                end else if (loaded_valid_q && (bus.rd_profile == loaded_prof_q)) begin
                    state_d = ST_DMA_CMD;
                end else begin
                    state_d = ST_RCFG;
                end
            end
            ST_RCFG: begin
                if (bus.rcfg_ack) begin
                    loaded_prof_d  = cur_prof_q;
                    loaded_valid_d = 1'b1;
                    state_d        = ST_DMA_CMD;
                end else if (timeout_hit) begin
                    loaded_valid_d = 1'b0;
                    result_d       = STATUS_WIDTH'(STATUS_ERROR);
                    state_d        = ST_WRBACK;
                end
            end
            ST_DMA_CMD: begin
                if (cur_size_q == '0) begin
                    result_d = STATUS_WIDTH'(STATUS_DONE);
                    state_d  = ST_WRBACK;
                end else if (bus.dma_cmd_ready) begin
                    state_d = ST_DMA_WAIT;
                end else if (timeout_hit) begin
                    result_d = STATUS_WIDTH'(STATUS_ERROR);
                    state_d  = ST_WRBACK;
                end
            end
            ST_DMA_WAIT: begin
                if (bus.dma_done) begin
                    result_d = bus.dma_err ? STATUS_WIDTH'(STATUS_ERROR)
                                           : STATUS_WIDTH'(STATUS_DONE);
                    state_d  = ST_WRBACK;
                end else if (timeout_hit) begin
                    result_d = STATUS_WIDTH'(STATUS_ERROR);
                    state_d  = ST_WRBACK;
                end
            end
            ST_WRBACK: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == INPUT_IDX_WIDTH'(NUM_SLOTS - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + INPUT_IDX_WIDTH'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state only. A zero-size slot
    // never raises dma_cmd_valid, and payload fields read 0 while unqualified.
    always_comb begin
        bus.busy          = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        bus.pass_done     = (state_q == ST_FINISH);
        bus.rd_idx        = idx_q;
        bus.wr_idx        = idx_q;
        bus.wr_set_status = (state_q == ST_WRBACK);
        bus.wr_status     = (state_q == ST_WRBACK) ? result_q : '0;
        bus.rcfg_req      = (state_q == ST_RCFG);
        bus.rcfg_profile  = (state_q == ST_RCFG) ? cur_prof_q : '0;
        bus.dma_cmd_valid = (state_q == ST_DMA_CMD) && (cur_size_q != '0);
        bus.dma_cmd_addr  = bus.dma_cmd_valid ? cur_addr_q : '0;
        bus.dma_cmd_size  = bus.dma_cmd_valid ? cur_size_q : '0;
    end

endmodule

// File: tb/tb_slot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_slot_sequencer
// Self-checking bench for slot_sequencer: a two-entry slot bank model, a DFX
// model acking three cycles after a request, and a DMA model completing five
// cycles after each accepted command. Table-driven passes plus hand-written
// sequences for back-pressure, mid-transfer reset and (with
// SLOT_SEQ_TIMEOUT_EN) the watchdog.
// ----------------------------------------------------------------------------
module tb_slot_sequencer;
    import slot_pkg::*;

    localparam int unsigned TB_TIMEOUT = 16;

    logic clk;
    logic reset;

    slot_sequencer_if #(
        .INPUT_IDX_WIDTH(1), .SRC_ADDR_WIDTH(32), .SRC_SIZE_WIDTH(26),
        .STATUS_WIDTH(2), .PROFILE_WIDTH(4)
    ) bus ();

    slot_sequencer #(
        .NUM_SLOTS(2), .INPUT_IDX_WIDTH(1), .SRC_ADDR_WIDTH(32),
        .SRC_SIZE_WIDTH(26), .STATUS_WIDTH(2), .PROFILE_WIDTH(4),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  st0, st1;
        logic [3:0]  pf0, pf1;
        logic [31:0] ad0, ad1;
        logic [25:0] sz0, sz1;
        logic        err0, err1;
        logic [1:0]  expSt0, expSt1;
        int          expRcfg;
        logic [3:0]  expProf;
        int          expDma;
        logic [31:0] expAddr;
        logic [25:0] expSize;
        int          expWr;
    } vec_t;

    int testsRun;
    int testsFailed;

    logic [1:0]  initStatus [0:1];
    logic [1:0]  slotStatus [0:1];
    logic [3:0]  slotProf   [0:1];
    logic [31:0] slotAddr   [0:1];
    logic [25:0] slotSize   [0:1];
    logic        slotErr    [0:1];
    logic        autoAck;

    int          rcfgCnt, rcfgHiCnt, dmaCnt, wrCnt, passCnt;
    logic        rcfgPrev;
    logic [3:0]  firstProf;
    logic [31:0] firstAddr;
    logic [25:0] firstSize;
    int          ackDelay, dmaDelay;
    logic        dmaPend, dmaPendErr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.rd_status   = slotStatus[bus.rd_idx];
    assign bus.rd_profile  = slotProf[bus.rd_idx];
    assign bus.rd_src_addr = slotAddr[bus.rd_idx];
    assign bus.rd_src_size = slotSize[bus.rd_idx];

    // Environment models and monitors. Reset reloads the slot bank, cancels
    // outstanding DFX/DMA work and clears every observation counter.
    always @(posedge clk) begin
        if (reset) begin
            slotStatus[0] <= initStatus[0];
            slotStatus[1] <= initStatus[1];
            bus.rcfg_ack  <= 1'b0;
            bus.dma_done  <= 1'b0;
            bus.dma_err   <= 1'b0;
            rcfgCnt       <= 0;
            rcfgHiCnt     <= 0;
            dmaCnt        <= 0;
            wrCnt         <= 0;
            passCnt       <= 0;
            rcfgPrev      <= 1'b0;
            firstProf     <= '0;
            firstAddr     <= '0;
            firstSize     <= '0;
            ackDelay      <= 0;
            dmaDelay      <= 0;
            dmaPend       <= 1'b0;
            dmaPendErr    <= 1'b0;
        end else begin
            bus.rcfg_ack <= 1'b0;
            bus.dma_done <= 1'b0;
            bus.dma_err  <= 1'b0;
            if (bus.wr_set_status) begin
                slotStatus[bus.wr_idx] <= bus.wr_status;
                wrCnt <= wrCnt + 1;
            end
            if (bus.pass_done) passCnt <= passCnt + 1;
            rcfgPrev <= bus.rcfg_req;
            if (bus.rcfg_req) rcfgHiCnt <= rcfgHiCnt + 1;
            if (bus.rcfg_req && !rcfgPrev) begin
                rcfgCnt <= rcfgCnt + 1;
                if (rcfgCnt == 0) firstProf <= bus.rcfg_profile;
            end
            if (!autoAck) begin
                ackDelay <= 0;
            end else if (bus.rcfg_req && !bus.rcfg_ack) begin
                if (ackDelay == 2) begin
                    bus.rcfg_ack <= 1'b1;
                    ackDelay     <= 0;
                end else begin
                    ackDelay <= ackDelay + 1;
                end
            end
            if (dmaPend) begin
                if (dmaDelay == 4) begin
                    bus.dma_done <= 1'b1;
                    bus.dma_err  <= dmaPendErr;
                    dmaPend      <= 1'b0;
                end else begin
                    dmaDelay <= dmaDelay + 1;
                end
            end else if (bus.dma_cmd_valid && bus.dma_cmd_ready) begin
                dmaPend    <= 1'b1;
                dmaDelay   <= 0;
                dmaPendErr <= slotErr[bus.rd_idx];
                dmaCnt     <= dmaCnt + 1;
                if (dmaCnt == 0) begin
                    firstAddr <= bus.dma_cmd_addr;
                    firstSize <= bus.dma_cmd_size;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadSlots(input vec_t v);
        initStatus[0] = v.st0;  initStatus[1] = v.st1;
        slotProf[0]   = v.pf0;  slotProf[1]   = v.pf1;
        slotAddr[0]   = v.ad0;  slotAddr[1]   = v.ad1;
        slotSize[0]   = v.sz0;  slotSize[1]   = v.sz1;
        slotErr[0]    = v.err0; slotErr[1]    = v.err1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        loadSlots(v);
        doReset();
        pulseStart();
    endtask

    task automatic waitPass(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (passCnt != 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_pass_done"}, 64'(passCnt), 64'd1);
    endtask

    vec_t vecs [0:4];
    vec_t v;

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        reset         = 1'b1;
        autoAck       = 1'b1;
        bus.start     = 1'b0;
        bus.dma_cmd_ready = 1'b1;

        vecs[0] = '{STATUS_READY, STATUS_READY, 4'd3, 4'd3, 32'h1000_0000, 32'h2000_0040,
                    26'd256, 26'd512, 1'b0, 1'b0, STATUS_DONE, STATUS_DONE,
                    1, 4'd3, 2, 32'h1000_0000, 26'd256, 2};
        vecs[1] = '{STATUS_EMPTY, STATUS_READY, 4'd7, 4'd5, 32'h0000_3000, 32'h0000_4000,
                    26'd64, 26'd128, 1'b0, 1'b0, STATUS_EMPTY, STATUS_DONE,
                    1, 4'd5, 1, 32'h0000_4000, 26'd128, 1};
        vecs[2] = '{STATUS_READY, STATUS_READY, 4'd1, 4'd2, 32'h0000_5000, 32'h0000_6000,
                    26'd8, 26'd16, 1'b1, 1'b0, STATUS_ERROR, STATUS_DONE,
                    2, 4'd1, 2, 32'h0000_5000, 26'd8, 2};
        vecs[3] = '{STATUS_READY, STATUS_READY, 4'd4, 4'd4, 32'h0000_7000, 32'h0000_8000,
                    26'd0, 26'd8, 1'b0, 1'b0, STATUS_DONE, STATUS_DONE,
                    1, 4'd4, 1, 32'h0000_8000, 26'd8, 2};
        vecs[4] = '{STATUS_DONE, STATUS_ERROR, 4'd2, 4'd2, 32'h0000_9000, 32'h0000_A000,
                    26'd4, 26'd4, 1'b0, 1'b0, STATUS_DONE, STATUS_ERROR,
                    0, 4'd0, 0, 32'h0, 26'd0, 0};

        // Reset state of every output.
        loadSlots(vecs[0]);
        doReset();
        checkOutput("reset_ctrl", {59'd0, bus.busy, bus.pass_done, bus.rcfg_req,
                    bus.dma_cmd_valid, bus.wr_set_status}, 64'd0);
        checkOutput("reset_data", {bus.dma_cmd_addr, bus.dma_cmd_size, bus.rcfg_profile,
                    bus.wr_status}, 64'd0);

        // Table-driven full passes.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            applyStimulus(v);
            waitPass($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_status0", i), 64'(slotStatus[0]), 64'(v.expSt0));
            checkOutput($sformatf("vec%0d_status1", i), 64'(slotStatus[1]), 64'(v.expSt1));
            checkOutput($sformatf("vec%0d_rcfg_cnt", i), 64'(rcfgCnt), 64'(v.expRcfg));
            checkOutput($sformatf("vec%0d_rcfg_prof", i), 64'(firstProf), 64'(v.expProf));
            checkOutput($sformatf("vec%0d_dma_cnt", i), 64'(dmaCnt), 64'(v.expDma));
            checkOutput($sformatf("vec%0d_dma_addr", i), 64'(firstAddr), 64'(v.expAddr));
            checkOutput($sformatf("vec%0d_dma_size", i), 64'(firstSize), 64'(v.expSize));
            checkOutput($sformatf("vec%0d_wr_cnt", i), 64'(wrCnt), 64'(v.expWr));
            checkOutput($sformatf("vec%0d_busy_after", i), 64'(bus.busy), 64'd0);
        end

        // Back-pressure: command held stable for 10 cycles, fires on first ready.
        v = vecs[0];
        loadSlots(v);
        doReset();
        bus.dma_cmd_ready = 1'b0;
        pulseStart();
        for (int i = 0; i < 100; i++) begin
            if (bus.dma_cmd_valid) break;
            @(negedge clk);
        end
        checkOutput("stall_valid_seen", 64'(bus.dma_cmd_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stall_hold%0d", i),
                        {5'd0, bus.dma_cmd_valid, bus.dma_cmd_size, bus.dma_cmd_addr},
                        {5'd0, 1'b1, v.sz0, v.ad0});
            @(negedge clk);
        end
        checkOutput("stall_no_transfer", 64'(dmaCnt), 64'd0);
        bus.dma_cmd_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_fire_cnt", 64'(dmaCnt), 64'd1);
        checkOutput("stall_valid_drop", 64'(bus.dma_cmd_valid), 64'd0);
        waitPass("stall");
        checkOutput("stall_status1", 64'(slotStatus[1]), 64'(STATUS_DONE));

        // Reset in DMA_WAIT, then a new pass must reconfigure again.
        applyStimulus(v);
        for (int i = 0; i < 100; i++) begin
            if (dmaCnt != 0) break;
            @(negedge clk);
        end
        checkOutput("rst_in_wait_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_ctrl", {59'd0, bus.busy, bus.pass_done, bus.rcfg_req,
                    bus.dma_cmd_valid, bus.wr_set_status}, 64'd0);
        checkOutput("rst_mid_data", {bus.dma_cmd_addr, bus.dma_cmd_size, bus.rcfg_profile,
                    bus.wr_status}, 64'd0);
        reset = 1'b0;
        pulseStart();
        waitPass("rst_rerun");
        checkOutput("rst_rerun_rcfg_cnt", 64'(rcfgCnt), 64'd1);
        checkOutput("rst_rerun_rcfg_prof", 64'(firstProf), 64'd3);
        checkOutput("rst_rerun_status0", 64'(slotStatus[0]), 64'(STATUS_DONE));

`ifdef SLOT_SEQ_TIMEOUT_EN
        // Watchdog: DFX never acks, slot0 written ERROR after 16 RCFG cycles.
        v = vecs[1];
        v.st0 = STATUS_READY;
        v.st1 = STATUS_EMPTY;
        v.pf0 = 4'd9;
        autoAck = 1'b0;
        applyStimulus(v);
        waitPass("timeout");
        checkOutput("timeout_status0", 64'(slotStatus[0]), 64'(STATUS_ERROR));
        checkOutput("timeout_rcfg_cycles", 64'(rcfgHiCnt), 64'(TB_TIMEOUT));
        checkOutput("timeout_dma_cnt", 64'(dmaCnt), 64'd0);
        autoAck = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
